auto_test_sequencer: RTL

Sequences the parameter-checking datapath through a fixed list of test steps. For each step it selects the signal source, waits for the signal to settle, enables the checker, and collects a fixed number of valid verdict samples. It then latches a per-step pass/fail result using a majority threshold. It sits between the front-panel start/abort controls and the threshold checker, and drives the source mux and the checker enable.

---
 rtl/auto_test_sequencer_pkg.sv | 33 +++
 rtl/auto_test_sequencer_sample_window_counter.sv | 39 +++
 rtl/auto_test_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/auto_test_sequencer_pkg.sv
// rtl/auto_test_sequencer_pkg.sv - shared state encoding, timing defaults and width helper
package auto_test_sequencer_pkg;

  localparam int CLK_HZ             = 100_000_000;
  // 10 ms of settling after every source switch
  localparam int DEF_SETTLE_CYCLES  = CLK_HZ / 100;
  // 0.5 s ceiling on a single MEASURE window
  localparam int DEF_TIMEOUT_CYCLES = CLK_HZ / 2;
  localparam int DEF_NUM_STEPS      = 4;
  localparam int DEF_SAMPLES        = 8;
  localparam int DEF_PASS_MIN       = 6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_JUDGE   = 3'd3,
    ST_NEXT    = 3'd4,
    ST_DONE    = 3'd5
  } ats_state_e;

  // Bits needed to hold values 0..value-1; never less than one bit so that
  // degenerate limits (1) still produce a legal vector.
  function automatic int ats_clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/auto_test_sequencer_sample_window_counter.sv
// rtl/auto_test_sequencer_sample_window_counter.sv - counts valid verdict samples and passes in one window
module sample_window_counter
  import auto_test_sequencer_pkg::*;
#(
  parameter int  SAMPLES = DEF_SAMPLES,
  localparam int CW      = ats_clog2(SAMPLES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          valid_in,
  input  logic          pass_in,
  output logic [CW-1:0] sample_cnt,
  output logic [CW-1:0] pass_cnt,
  output logic          window_full
);

  localparam logic [CW-1:0] CNT_FULL = CW'(SAMPLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLES - 1);

  // Asserted in the cycle whose sample completes the window, so the caller
  // can leave its measuring state without waiting for the register update.
  assign window_full = valid_in && !clear && (sample_cnt == CNT_LAST);

  // Sample/pass accumulation; clear wins, and the window stops at SAMPLES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      pass_cnt   <= '0;
    end else if (clear) begin
      sample_cnt <= '0;
      pass_cnt   <= '0;
    end else if (valid_in && (sample_cnt != CNT_FULL)) begin
      sample_cnt <= sample_cnt + CW'(1);
      pass_cnt   <= pass_cnt + CW'(pass_in);
    end
  end

endmodule

// File: rtl/auto_test_sequencer.sv
// rtl/auto_test_sequencer.sv - steps the checker through each source and latches per-step verdicts
module auto_test_sequencer
  import auto_test_sequencer_pkg::*;
#(
  parameter int  NUM_STEPS      = DEF_NUM_STEPS,
  parameter int  SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int  SAMPLES        = DEF_SAMPLES,
  parameter int  PASS_MIN       = DEF_PASS_MIN,
  parameter int  TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int SEL_W          = ats_clog2(NUM_STEPS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 valid_in,
  input  logic                 pass_in,
  output logic [SEL_W-1:0]     src_sel,
  output logic                 check_en,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_STEPS-1:0] step_pass,
  output logic                 overall_pass,
  output logic                 timeout_flag
);

  localparam int CNT_W = ats_clog2(SAMPLES + 1);
  localparam int SET_W = ats_clog2(SETTLE_CYCLES);
  localparam int TMO_W = ats_clog2(TIMEOUT_CYCLES);

  localparam logic [SEL_W-1:0] LAST_STEP   = SEL_W'(NUM_STEPS - 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PASS_MIN_C  = CNT_W'(PASS_MIN);
  localparam logic [CNT_W-1:0] SAMPLES_C   = CNT_W'(SAMPLES);

  ats_state_e       state;
  ats_state_e       state_n;
  logic [SEL_W-1:0] step;
  logic [SET_W-1:0] settle_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] pass_cnt;
  logic             window_full;
  logic             meas_valid;
  logic             win_clear;
  logic             start_hit;
  logic             abort_hit;
  logic             timeout_hit;

  // Abort outranks everything, including a start seen while idle.
  assign start_hit   = (state == ST_IDLE) && start && !abort;
  assign abort_hit   = (state != ST_IDLE) && abort;
  assign meas_valid  = (state == ST_MEASURE) && valid_in;
  assign win_clear   = (state != ST_MEASURE);
  // A sample completing the window in the last allowed cycle beats the timeout.
  assign timeout_hit = (state == ST_MEASURE) && (tmo_cnt == TMO_LAST) && !window_full;

  sample_window_counter #(
    .SAMPLES (SAMPLES)
  ) u_window (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (win_clear),
    .valid_in    (meas_valid),
    .pass_in     (pass_in),
    .sample_cnt  (sample_cnt),
    .pass_cnt    (pass_cnt),
    .window_full (window_full)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state decode and the state-derived control outputs.
  always_comb begin
    state_n  = state;
    check_en = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    src_sel  = step;
    case (state)
      ST_IDLE: begin
        if (start_hit) begin
          state_n = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        busy = 1'b1;
        if (settle_cnt == SETTLE_LAST) begin
          state_n = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        busy     = 1'b1;
        check_en = 1'b1;
        if (window_full || (tmo_cnt == TMO_LAST)) begin
          state_n = ST_JUDGE;
        end
      end
      ST_JUDGE: begin
        busy    = 1'b1;
        state_n = ST_NEXT;
      end
      ST_NEXT: begin
        busy = 1'b1;
        if (step == LAST_STEP) begin
          state_n = ST_DONE;
        end else begin
          state_n = ST_SETTLE;
          // Switch the mux one cycle early so settling starts with the new source.
          src_sel = step + SEL_W'(1);
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    if (abort_hit) begin
      state_n = ST_IDLE;
    end
  end

  // Settle and timeout counters: run only while staying in their state, saturate, clear otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      tmo_cnt    <= '0;
    end else begin
      if ((state == ST_SETTLE) && (state_n == ST_SETTLE)) begin
        if (settle_cnt != SETTLE_LAST) begin
          settle_cnt <= settle_cnt + SET_W'(1);
        end
      end else begin
        settle_cnt <= '0;
      end
      if ((state == ST_MEASURE) && (state_n == ST_MEASURE)) begin
        if (tmo_cnt != TMO_LAST) begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  // Step index and result registers; a step that ended without a full window is a forced fail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step         <= '0;
      step_pass    <= '0;
      overall_pass <= 1'b0;
      timeout_flag <= 1'b0;
    end else if (start_hit) begin
      step         <= '0;
      step_pass    <= '0;
      overall_pass <= 1'b0;
      timeout_flag <= 1'b0;
    end else if (abort_hit) begin
      overall_pass <= 1'b0;
    end else begin
      case (state)
        ST_MEASURE: begin
          if (timeout_hit) begin
            timeout_flag <= 1'b1;
          end
        end
        ST_JUDGE: begin
          step_pass[step] <= (pass_cnt >= PASS_MIN_C) && (sample_cnt == SAMPLES_C);
        end
        ST_NEXT: begin
          if (step == LAST_STEP) begin
            overall_pass <= &step_pass;
          end else begin
            step <= step + SEL_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
